// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: ALU operand forward selects, a multi-cycle
// stall/bubble FSM for load-use hazards, and a saturating stall-cycle counter.
module fwd_hazard_unit #(
   parameter int ADDR_W    = 2,
   parameter int LOAD_LAT  = 1,
   parameter int ZERO_REG  = 0,
   parameter int RF_BYPASS = 1,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs_ex,
   input  logic [ADDR_W-1:0] rt_ex,
   input  logic [ADDR_W-1:0] rd_ex,
   input  logic              memread_ex,
   input  logic [ADDR_W-1:0] rs_id,
   input  logic [ADDR_W-1:0] rt_id,
   input  logic              rs_used_id,
   input  logic              rt_used_id,
   input  logic [ADDR_W-1:0] rd_mem,
   input  logic              regwrite_mem,
   input  logic [ADDR_W-1:0] rd_wb,
   input  logic              regwrite_wb,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              stall_if,
   output logic              stall_id,
   output logic              flush_ex,
   output logic [CNT_W-1:0]  stall_count
);

   typedef enum logic {IDLE, STALL} state_t;

   localparam logic [3:0]       LAT_M1 = 4'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] hist_rd;
   logic              hist_v;
   logic              hz;
   logic              stall_raw;
   logic [1:0]        sel_a;
   logic [1:0]        sel_b;

   // Address 0 never matches when it is the hardwired zero register
   function automatic logic match(input logic [ADDR_W-1:0] x, input logic [ADDR_W-1:0] y);
      return (x == y) && !((ZERO_REG != 0) && (y == '0));
   endfunction

   // Youngest producer wins: MEM, then WB, then the post-WB history entry
   function automatic logic [1:0] fwd_sel(
      input logic [ADDR_W-1:0] src,
      input logic [ADDR_W-1:0] mem_rd,
      input logic              mem_we,
      input logic [ADDR_W-1:0] wb_rd,
      input logic              wb_we,
      input logic [ADDR_W-1:0] h_rd,
      input logic              h_v
   );
      if (mem_we && match(mem_rd, src))
         return 2'b10;
      else if (wb_we && match(wb_rd, src))
         return 2'b01;
      else if ((RF_BYPASS != 0) && h_v && match(h_rd, src))
         return 2'b11;
      else
         return 2'b00;
   endfunction

   generate
      if (RF_BYPASS != 0) begin : g_hist
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               hist_rd <= '0;
               hist_v  <= 1'b0;
            end else begin
               hist_rd <= rd_wb;
               hist_v  <= regwrite_wb;
            end
         end
      end else begin : g_no_hist
         assign hist_rd = '0;
         assign hist_v  = 1'b0;
      end
   endgenerate

   always_comb begin
      sel_a = fwd_sel(rs_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb, hist_rd, hist_v);
      sel_b = fwd_sel(rt_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb, hist_rd, hist_v);
      hz    = memread_ex && ((rs_used_id && match(rd_ex, rs_id)) ||
                             (rt_used_id && match(rd_ex, rt_id)));
   end

   // The first stall cycle comes straight from hz; STALL covers the remaining LOAD_LAT-1
   assign stall_raw = (state == STALL) || hz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hz && (LOAD_LAT > 1)) begin
                  state <= STALL;
                  cnt   <= LAT_M1;
               end
            end
            STALL: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_count <= '0;
      else if (stall_raw && (stall_count != '1))
         stall_count <= stall_count + ONE;
   end

   assign forward_a = rst ? 2'b00 : sel_a;
   assign forward_b = rst ? 2'b00 : sel_b;
   assign stall_if  = !rst && stall_raw;
   assign stall_id  = !rst && stall_raw;
   assign flush_ex  = !rst && stall_raw;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined core; successor to the 2-bit, MEM/WB-only forwarding mux selector.
- Generates ALU operand forward selects from the MEM, WB and post-WB (register-file bypass) stages.
- Detects load-use hazards and drives a multi-cycle stall/bubble FSM.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- ADDR_W, 2, register address width.
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..15).
- ZERO_REG, 0, 1 = address 0 is hardwired zero and never forwarded or hazarded.
- RF_BYPASS, 1, 1 = enable post-WB history forwarding (select 2'b11).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rs_ex  in  ADDR_W  source 1 address of the EX-stage instruction.
- rt_ex  in  ADDR_W  source 2 address of the EX-stage instruction.
- rd_ex  in  ADDR_W  destination address of the EX-stage instruction.
- memread_ex  in  1  EX-stage instruction is a load.
- rs_id  in  ADDR_W  source 1 address of the ID-stage instruction.
- rt_id  in  ADDR_W  source 2 address of the ID-stage instruction.
- rs_used_id  in  1  ID-stage instruction reads rs.
- rt_used_id  in  1  ID-stage instruction reads rt.
- rd_mem  in  ADDR_W  MEM-stage destination address.
- regwrite_mem  in  1  MEM-stage write enable.
- rd_wb  in  ADDR_W  WB-stage destination address.
- regwrite_wb  in  1  WB-stage write enable.
- forward_a  out  2  ALU A select: 00 register file, 10 MEM, 01 WB, 11 history.
- forward_b  out  2  ALU B select, same encoding.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_ex  out  1  insert bubble into ID/EX.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE; bubble counter and history valid are cleared; stall_count=0.
  - While rst=1, all outputs are forced to 0, including the combinational ones.
- Match qualifier: match(x, y) = (x == y) and not (ZERO_REG and y == 0).
- Forwarding (combinational, evaluated per operand; shown for A, B identical with rt_ex):
  - regwrite_mem and match(rd_mem, rs_ex) → 10 (highest priority).
  - else regwrite_wb and match(rd_wb, rs_ex) → 01. The WB stage's own regwrite_wb is used, not the MEM one.
  - else RF_BYPASS and hist_v and match(hist_rd, rs_ex) → 11.
  - else 00.
- History register:
  - Every clk edge: hist_rd <= rd_wb, hist_v <= regwrite_wb.
  - When RF_BYPASS=0, these registers are absent and forward select 11 is never produced.
- Load-use detect: hz = memread_ex and ((rs_used_id and match(rd_ex, rs_id)) or (rt_used_id and match(rd_ex, rt_id))).
- FSM states: IDLE, STALL. Counter cnt is 4 bits.
  - IDLE, hz=1: stall_if, stall_id and flush_ex are asserted the same cycle (combinational).
    - If LOAD_LAT=1, stay IDLE.
    - Otherwise go to STALL with cnt <= LOAD_LAT-1.
  - IDLE, hz=0: all stall outputs 0.
  - STALL: stall_if, stall_id and flush_ex are asserted every cycle; hz is ignored. cnt decrements each cycle; when cnt==1, the next state is IDLE.
  - Total stall-asserted cycles per hazard = LOAD_LAT exactly.
  - Back-to-back hazards: a new hz detected in the first IDLE cycle after STALL starts a new sequence with no gap.
- stall_count: increments by 1 on each clk edge where stall_if=1; saturates at all-ones with no wrap.
- Reset mid-STALL: outputs drop immediately; after release the FSM is in IDLE and no residual bubbles are produced.
- Simultaneous MEM and WB match on the same address: MEM wins (youngest data).
- Operand matching both rs and rt: each select is decided independently.

Test Plan:
- MEM forwarding: regwrite_mem=1, rd_mem=2, rs_ex=2, rt_ex=1, regwrite_wb=1, rd_wb=1 → forward_a=10, forward_b=01.
- Priority and WB enable: rd_mem=rd_wb=3=rs_ex, both write enables 1 → forward_a=10. Then regwrite_mem=0 → 01. Then regwrite_wb=0 → 00.
- History forwarding: WB writes r1 (rd_wb=1, regwrite_wb=1); next cycle regwrite_wb=0, no MEM match, rs_ex=1 → forward_a=11. With RF_BYPASS=0 → 00.
- Zero register: ZERO_REG=1, rd_mem=0=rs_ex, regwrite_mem=1 → forward_a=00. Load to r0 with rs_id=0, rs_used_id=1 → no stall.
- Load-use stall length: LOAD_LAT=3, memread_ex=1, rd_ex=2, rt_id=2, rt_used_id=1 for one cycle → stall_if/stall_id/flush_ex high exactly 3 cycles; stall_count=3. Repeat with LOAD_LAT=1 → 1 cycle.
- Reset and saturation: assert rst in the second STALL cycle → outputs 0 immediately; after release, zero stall cycles and stall_count=0. Force 2^CNT_W+5 stall cycles → stall_count holds at all-ones.
